seq_div: RTL and testbench

- Sequential shift-and-subtract (restoring) divider; the inverse companion of the shift-and-add multiplier.
- Divides a 2N-bit dividend by an N-bit divisor, one quotient bit per cycle, and returns a 2N-bit quotient and an N-bit remainder.
- Used for reduction and quotient checks on full-width products in the mod-p arithmetic datapath.
- Trades speed for area: one N+1-bit subtractor, no array logic.

---
 rtl/seq_div.sv | 116 +++++++++++
 tb/tb_seq_div.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_div.sv
// Restoring shift-and-subtract divider. It divides a 2N-bit dividend by an
// N-bit divisor and retires one quotient bit per clock.
module seq_div #(
    parameter int N = 256
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           ready,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] quot,
    output logic [N-1:0]   rem,
    output logic           dbz
);

    localparam int            CW   = $clog2(2*N) + 1;
    localparam logic [CW-1:0] LAST = CW'(2*N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state, state_next;
    logic [2*N-1:0] q_reg, q_next;
    logic [N-1:0]   d_reg;
    // The partial remainder always stays below the divisor, so its top bit is
    // always zero and is not stored. The trial value below restores that bit.
    logic [N-1:0]   r_reg, r_next;
    logic [CW-1:0]  cnt, cnt_next;
    logic [N:0]     trial, diff;
    logic           fits, div_zero, last_step, unused_diff_msb;

    always_comb begin
        trial           = {r_reg, q_reg[2*N-1]};
        fits            = (trial >= {1'b0, d_reg});
        diff            = trial - {1'b0, d_reg};
        unused_diff_msb = diff[N];
        r_next          = fits ? diff[N-1:0] : trial[N-1:0];
        q_next          = {q_reg[2*N-2:0], fits};
        cnt_next        = cnt + CW'(1);
        last_step       = (cnt_next == LAST);
        div_zero        = (divisor == '0);
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) state_next = div_zero ? DONE : DIV;
            end
            DIV: begin
                busy = 1'b1;
                if (last_step) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Results are loaded only on the edge that enters DONE. They hold until
    // the next operation completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            q_reg <= '0;
            d_reg <= '0;
            r_reg <= '0;
            cnt   <= '0;
            quot  <= '0;
            rem   <= '0;
            dbz   <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        q_reg <= dividend;
                        d_reg <= divisor;
                        r_reg <= '0;
                        cnt   <= '0;
                        if (div_zero) begin
                            quot <= '1;
                            rem  <= dividend[N-1:0];
                            dbz  <= 1'b1;
                        end
                    end
                end
                DIV: begin
                    q_reg <= q_next;
                    r_reg <= r_next;
                    cnt   <= cnt_next;
                    if (last_step) begin
                        quot <= q_next;
                        rem  <= r_next;
                        dbz  <= 1'b0;
                    end
                end
                DONE: cnt <= '0;
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div. It runs an N=8 and an N=256 instance and
// checks both against a timeline model built on plain division.
module tb_seq_div;

    localparam int NS = 8;
    localparam int NL = 256;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic            s_start = 1'b0;
    logic [2*NS-1:0] s_dvd   = '0;
    logic [NS-1:0]   s_dvs   = '0;
    logic            s_ready, s_busy, s_done, s_dbz;
    logic [2*NS-1:0] s_quot;
    logic [NS-1:0]   s_rem;

    logic            l_start = 1'b0;
    logic [2*NL-1:0] l_dvd   = '0;
    logic [NL-1:0]   l_dvs   = '0;
    logic            l_ready, l_busy, l_done, l_dbz;
    logic [2*NL-1:0] l_quot;
    logic [NL-1:0]   l_rem;

    seq_div #(.N(NS)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(s_start), .dividend(s_dvd), .divisor(s_dvs),
        .ready(s_ready), .busy(s_busy), .done(s_done), .quot(s_quot), .rem(s_rem), .dbz(s_dbz)
    );

    seq_div #(.N(NL)) dut_l (
        .clk(clk), .rst_n(rst_n), .start(l_start), .dividend(l_dvd), .divisor(l_dvs),
        .ready(l_ready), .busy(l_busy), .done(l_done), .quot(l_quot), .rem(l_rem), .dbz(l_dbz)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic reportTimeout(input string name);
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL %s: done never arrived within the cycle budget", name);
    endtask

    // Timeline model: an accepted operation finishes 2N edges after the
    // accepting edge (same edge for divide-by-zero), and the divider is
    // idle again one edge after the done cycle.
    longint      cyc = 0;
    bit          m_pend[2];
    longint      m_done[2];
    logic [511:0] m_q[2], m_hq[2], m_dvd[2];
    logic [255:0] m_r[2], m_hr[2], m_dvs[2];
    bit          m_dbz[2], m_hdbz[2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_pend[k] = 1'b0;
                m_hq[k]   = '0;
                m_hr[k]   = '0;
                m_hdbz[k] = 1'b0;
            end
        end else begin
            cyc++;
            for (int k = 0; k < 2; k++) begin
                int           n;
                bit           idle, go;
                logic [511:0] a;
                logic [255:0] b;
                n    = (k == 0) ? NS : NL;
                go   = (k == 0) ? s_start : l_start;
                a    = (k == 0) ? 512'(s_dvd) : l_dvd;
                b    = (k == 0) ? 256'(s_dvs) : l_dvs;
                idle = !m_pend[k];
                if (m_pend[k] && cyc == m_done[k] + 1) m_pend[k] = 1'b0;
                if (idle && go) begin
                    m_pend[k] = 1'b1;
                    m_dvd[k]  = a;
                    m_dvs[k]  = b;
                    if (b == '0) begin
                        m_q[k]    = (k == 0) ? 512'hFFFF : {512{1'b1}};
                        m_r[k]    = a[255:0] & ((k == 0) ? 256'hFF : {256{1'b1}});
                        m_dbz[k]  = 1'b1;
                        m_done[k] = cyc;
                    end else begin
                        m_q[k]    = a / 512'(b);
                        m_r[k]    = 256'(a % 512'(b));
                        m_dbz[k]  = 1'b0;
                        m_done[k] = cyc + longint'(2 * n);
                    end
                end
                if (m_pend[k] && cyc == m_done[k]) begin
                    m_hq[k]   = m_q[k];
                    m_hr[k]   = m_r[k];
                    m_hdbz[k] = m_dbz[k];
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit           e_done, e_busy, e_ready;
            string        tag;
            logic [767:0] prod;
            tag     = (k == 0) ? "n8" : "n256";
            e_done  = m_pend[k] && (cyc == m_done[k]);
            e_busy  = m_pend[k] && (cyc < m_done[k]);
            e_ready = !m_pend[k];
            if (k == 0) begin
                checkOutput({tag, " done"},  512'(s_done),  512'(e_done));
                checkOutput({tag, " busy"},  512'(s_busy),  512'(e_busy));
                checkOutput({tag, " ready"}, 512'(s_ready), 512'(e_ready));
                checkOutput({tag, " quot"},  512'(s_quot),  m_hq[0]);
                checkOutput({tag, " rem"},   512'(s_rem),   512'(m_hr[0]));
                checkOutput({tag, " dbz"},   512'(s_dbz),   512'(m_hdbz[0]));
            end else begin
                checkOutput({tag, " done"},  512'(l_done),  512'(e_done));
                checkOutput({tag, " busy"},  512'(l_busy),  512'(e_busy));
                checkOutput({tag, " ready"}, 512'(l_ready), 512'(e_ready));
                checkOutput({tag, " quot"},  l_quot,        m_hq[1]);
                checkOutput({tag, " rem"},   512'(l_rem),   512'(m_hr[1]));
                checkOutput({tag, " dbz"},   512'(l_dbz),   512'(m_hdbz[1]));
                if (e_done && !m_hdbz[1]) begin
                    prod = 768'(l_quot) * 768'(m_dvs[1]) + 768'(l_rem);
                    checkOutput("n256 q*d+r==dividend", 512'(prod == 768'(m_dvd[1])), 512'(1));
                    checkOutput("n256 rem<divisor", 512'(l_rem < m_dvs[1]), 512'(1));
                end
            end
        end
    end

    task automatic waitSmallDone(input string name, output int lat, output int bc);
        lat = 0;
        bc  = int'(s_busy);
        while (!s_done && lat < 100) begin
            @(negedge clk);
            lat++;
            if (s_busy) bc++;
        end
        if (!s_done) reportTimeout(name);
    endtask

    task automatic applyStimulus(input logic [15:0] a, input logic [7:0] b, output int lat, output int bc);
        int guard = 0;
        @(negedge clk);
        while (!s_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        s_dvd   = a;
        s_dvs   = b;
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        s_dvd   = 16'($urandom);
        s_dvs   = 8'($urandom);
        waitSmallDone("n8 op", lat, bc);
    endtask

    task automatic applyStimulusWide(input logic [511:0] a, input logic [255:0] b, output int lat);
        int guard = 0;
        @(negedge clk);
        while (!l_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        l_dvd   = a;
        l_dvs   = b;
        l_start = 1'b1;
        @(negedge clk);
        l_start = 1'b0;
        l_dvd   = ~a;
        l_dvs   = ~b;
        lat     = 0;
        while (!l_done && lat < 700) begin
            @(negedge clk);
            lat++;
        end
        if (!l_done) reportTimeout("n256 op");
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    logic [15:0] c_dvd[6] = '{16'hFFFF, 16'hFFFF, 16'd5, 16'd0,    16'h1234, 16'd20};
    logic [7:0]  c_dvs[6] = '{8'hFF,    8'd1,     8'd9,  8'h80,    8'd0,     8'd3};
    logic [15:0] c_q[6]   = '{16'h0101, 16'hFFFF, 16'd0, 16'd0,    16'hFFFF, 16'd6};
    logic [7:0]  c_r[6]   = '{8'd0,     8'd0,     8'd5,  8'd0,     8'h34,    8'd2};
    logic        c_z[6]   = '{1'b0,     1'b0,     1'b0,  1'b0,     1'b1,     1'b0};
    int          c_lat[6] = '{16, 16, 16, 16, 0, 16};

    initial begin
        int     lat, bc, guard;
        longint t1, t2;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset quot",  512'(s_quot),  512'(0));
        checkOutput("reset ready", 512'(s_ready), 512'(1));
        #2 rst_n = 1'b1;

        applyStimulus(16'd1000, 8'd7, lat, bc);
        checkOutput("1000/7 quot",    512'(s_quot), 512'(142));
        checkOutput("1000/7 rem",     512'(s_rem),  512'(6));
        checkOutput("1000/7 dbz",     512'(s_dbz),  512'(0));
        checkOutput("1000/7 latency", 512'(lat),    512'(16));
        checkOutput("1000/7 busy cycles", 512'(bc), 512'(16));

        for (int i = 0; i < 6; i++) begin
            applyStimulus(c_dvd[i], c_dvs[i], lat, bc);
            checkOutput($sformatf("corner%0d quot", i),    512'(s_quot), 512'(c_q[i]));
            checkOutput($sformatf("corner%0d rem", i),     512'(s_rem),  512'(c_r[i]));
            checkOutput($sformatf("corner%0d dbz", i),     512'(s_dbz),  512'(c_z[i]));
            checkOutput($sformatf("corner%0d latency", i), 512'(lat),    512'(c_lat[i]));
        end

        // Start held high: mid-operation operands and the DONE cycle are ignored.
        @(negedge clk);
        s_dvd   = 16'd1000;
        s_dvs   = 8'd7;
        s_start = 1'b1;
        repeat (5) @(negedge clk);
        s_dvd = 16'hFFFF;
        s_dvs = 8'd1;
        waitSmallDone("hold op1", lat, bc);
        t1 = cyc;
        checkOutput("hold op1 quot", 512'(s_quot), 512'(142));
        checkOutput("hold op1 rem",  512'(s_rem),  512'(6));
        s_dvd = 16'hAAAA;
        s_dvs = 8'd3;
        @(negedge clk);
        s_dvd = 16'd20;
        s_dvs = 8'd3;
        @(negedge clk);
        s_dvd = 16'h5555;
        s_dvs = 8'd2;
        repeat (5) @(negedge clk);
        s_start = 1'b0;
        waitSmallDone("hold op2", lat, bc);
        t2 = cyc;
        checkOutput("hold done spacing", 512'(t2 - t1), 512'(18));
        checkOutput("hold op2 quot", 512'(s_quot), 512'(6));
        checkOutput("hold op2 rem",  512'(s_rem),  512'(2));

        // Asynchronous reset in the middle of a division.
        @(negedge clk);
        s_dvd   = 16'd1000;
        s_dvs   = 8'd7;
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async rst quot",  512'(s_quot),  512'(0));
        checkOutput("async rst rem",   512'(s_rem),   512'(0));
        checkOutput("async rst done",  512'(s_done),  512'(0));
        checkOutput("async rst busy",  512'(s_busy),  512'(0));
        checkOutput("async rst ready", 512'(s_ready), 512'(1));
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("no done after reset", 512'(s_done), 512'(0));
        end
        applyStimulus(16'd1000, 8'd7, lat, bc);
        checkOutput("post-reset quot", 512'(s_quot), 512'(142));
        checkOutput("post-reset rem",  512'(s_rem),  512'(6));

        applyStimulusWide(512'd1 << 300, 256'd1 << 100, lat);
        checkOutput("wide pow2 quot",    l_quot,       512'd1 << 200);
        checkOutput("wide pow2 rem",     512'(l_rem),  512'(0));
        checkOutput("wide pow2 latency", 512'(lat),    512'(512));

        fork
            begin
                for (int i = 0; i < 1200; i++) begin
                    logic [15:0] a;
                    logic [7:0]  b;
                    a = 16'($urandom);
                    case ($urandom_range(0, 7))
                        0:       b = 8'd0;
                        1:       b = 8'd1;
                        2:       b = 8'hFF;
                        3:       b = 8'($urandom_range(1, 15));
                        default: b = 8'($urandom);
                    endcase
                    applyStimulus(a, b, lat, bc);
                    checkOutput("n8 random latency", 512'(lat), 512'((b == 8'd0) ? 0 : 16));
                end
            end
            begin
                for (int i = 0; i < 60; i++) begin
                    logic [511:0] a;
                    logic [255:0] b, x, y;
                    int           wl;
                    a = rand512();
                    b = 256'(rand512());
                    case (i)
                        0: begin
                            b = (256'd1 << 255) - 256'd19;
                            x = 256'(rand512()) >> 1;
                            y = 256'(rand512()) >> 1;
                            a = 512'(x) * 512'(y);
                        end
                        1: b = 256'd1;
                        2: b = '0;
                        3: begin
                            a = {512{1'b1}};
                            b = {256{1'b1}};
                        end
                        default: b = b >> $urandom_range(0, 255);
                    endcase
                    applyStimulusWide(a, b, wl);
                    checkOutput("n256 random latency", 512'(wl), 512'((b == '0) ? 0 : 512));
                end
            end
        join

        guard = 0;
        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #5_000_000;
        tests_failed++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
